instruction_fetch_unit: RTL and testbench

Fetch stage that owns the program counter and drives the 8-bit address of the combinational instruction memory. It captures the returned 8-bit instruction into a small prefetch FIFO and presents {PC, instruction} to decode over a valid/ready handshake. It supports branch redirect with flush, and halts fetching after a HALT opcode is fetched.

---
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, queues {PC, instruction} pairs in a
// small prefetch FIFO and hands them to decode over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int          DEPTH       = 2,
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [7:0] Address,
    input  logic [7:0] Instruction,
    input  logic       Branch_Valid,
    input  logic [7:0] Branch_Target,
    output logic       Out_Valid,
    output logic [7:0] Out_Instruction,
    output logic [7:0] Out_PC,
    input  logic       Out_Ready,
    output logic       Halted
);

    // state | meaning
    // RUN   | fetching one instruction per cycle while the FIFO has room
    // HALT  | HALT opcode queued; PC frozen, FIFO drains, waits for a branch
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t         state_q, state_d;
    logic [7:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]     fifo_pc_q    [DEPTH];
    logic [7:0]     fifo_pc_d    [DEPTH];
    logic [7:0]     fifo_instr_q [DEPTH];
    logic [7:0]     fifo_instr_d [DEPTH];

    logic push;
    logic pop;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= fifo_pc_d[i];
                fifo_instr_q[i] <= fifo_instr_d[i];
            end
        end
    end

    // A full FIFO still accepts a fetch when its head leaves in the same cycle.
    always_comb begin
        pop  = (count_q != '0) & Out_Ready;
        push = (state_q == RUN) & ~Branch_Valid & ((count_q < DEPTH_C) | pop);
    end

    always_comb begin
        state_d = state_q;
        if (Branch_Valid) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (push && (Instruction == HALT_OPCODE)) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    // Datapath: PC, pointers, occupancy and storage. A branch discards every
    // queued entry, including a head that decode is accepting this cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_d[i]    = fifo_pc_q[i];
            fifo_instr_d[i] = fifo_instr_q[i];
        end

        if (Branch_Valid) begin
            fetch_pc_d = Branch_Target;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
                fifo_instr_d[wr_ptr_q] = Instruction;
                wr_ptr_d               = wr_ptr_q + PW'(1);
                fetch_pc_d             = fetch_pc_q + 8'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        Halted          = (state_q == HALT);
        Address         = fetch_pc_q;
        Out_Valid       = (count_q != '0);
        Out_PC          = fifo_pc_q[rd_ptr_q];
        Out_Instruction = fifo_instr_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational instruction
// memory model; all checks are made on the falling clock edge.
module tb_instruction_fetch_unit;

    logic       Clk;
    logic       Reset;
    logic [7:0] Address;
    logic [7:0] Instruction;
    logic       Branch_Valid;
    logic [7:0] Branch_Target;
    logic       Out_Valid;
    logic [7:0] Out_Instruction;
    logic [7:0] Out_PC;
    logic       Out_Ready;
    logic       Halted;

    logic [7:0] imem [256];

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(
        .DEPTH      (2),
        .RESET_PC   (8'h00),
        .HALT_OPCODE(8'hFF)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Address        (Address),
        .Instruction    (Instruction),
        .Branch_Valid   (Branch_Valid),
        .Branch_Target  (Branch_Target),
        .Out_Valid      (Out_Valid),
        .Out_Instruction(Out_Instruction),
        .Out_PC         (Out_PC),
        .Out_Ready      (Out_Ready),
        .Halted         (Halted)
    );

    assign Instruction = imem[Address];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic reset_pulse();
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
    endtask

    initial begin
        // Default contents are even, so never the HALT opcode.
        for (int i = 0; i < 256; i++) imem[i] = 8'((i << 1) & 8'hFE);
        imem[0]    = 8'h11;
        imem[1]    = 8'h22;
        imem[2]    = 8'h33;
        imem[3]    = 8'h44;
        imem[5]    = 8'hFF;
        imem[8'h80] = 8'hA5;
        imem[8'h81] = 8'h5A;

        Reset         = 1'b1;
        Branch_Valid  = 1'b0;
        Branch_Target = 8'h00;
        Out_Ready     = 1'b1;
        cyc(2);
        Reset = 1'b0;

        check("rst_valid",  Out_Valid, 0);
        check("rst_addr",   Address, 8'h00);
        check("rst_pc",     Out_PC, 0);
        check("rst_instr",  Out_Instruction, 0);
        check("rst_halted", Halted, 0);

        // Back-to-back streaming.
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("stream_valid", Out_Valid, 1);
            check("stream_pc",    Out_PC, k);
            check("stream_instr", Out_Instruction, imem[k]);
        end

        // Backpressure from reset: FIFO saturates at 2 entries.
        Out_Ready = 1'b0;
        reset_pulse();
        cyc(4);
        check("bp_addr",  Address, 8'h02);
        check("bp_valid", Out_Valid, 1);
        check("bp_pc",    Out_PC, 0);
        check("bp_instr", Out_Instruction, 8'h11);
        cyc(1);
        check("bp_stable_pc", Out_PC, 0);
        Out_Ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cyc(1);
            check("bp_drain_valid", Out_Valid, 1);
            check("bp_drain_pc",    Out_PC, k);
        end

        // Branch while full and decode ready.
        Out_Ready = 1'b0;
        reset_pulse();
        cyc(3);
        check("br_full_valid", Out_Valid, 1);
        Branch_Valid  = 1'b1;
        Branch_Target = 8'h80;
        Out_Ready     = 1'b1;
        cyc(1);
        Branch_Valid = 1'b0;
        check("br_flush_valid", Out_Valid, 0);
        check("br_addr",        Address, 8'h80);
        cyc(1);
        check("br_tgt_valid", Out_Valid, 1);
        check("br_tgt_pc",    Out_PC, 8'h80);
        check("br_tgt_instr", Out_Instruction, 8'hA5);
        cyc(1);
        check("br_next_pc",    Out_PC, 8'h81);
        check("br_next_instr", Out_Instruction, 8'h5A);

        // HALT at PC 5.
        reset_pulse();
        cyc(5);
        check("pre_halt_halted", Halted, 0);
        check("pre_halt_pc",     Out_PC, 4);
        cyc(1);
        check("halt_halted", Halted, 1);
        check("halt_pc",     Out_PC, 5);
        check("halt_instr",  Out_Instruction, 8'hFF);
        check("halt_addr",   Address, 8'h06);
        cyc(1);
        check("halt_drained", Out_Valid, 0);
        check("halt_addr2",   Address, 8'h06);
        check("halt_stays",   Halted, 1);
        cyc(2);
        check("halt_idle_valid", Out_Valid, 0);
        Branch_Valid  = 1'b1;
        Branch_Target = 8'h10;
        cyc(1);
        Branch_Valid = 1'b0;
        check("resume_halted", Halted, 0);
        check("resume_addr",   Address, 8'h10);
        check("resume_valid",  Out_Valid, 0);
        cyc(1);
        check("resume_pc",    Out_PC, 8'h10);
        check("resume_instr", Out_Instruction, 8'h20);

        // Branch coincident with fetching the HALT opcode: branch wins.
        Branch_Valid  = 1'b1;
        Branch_Target = 8'h05;
        cyc(1);
        check("coin_addr", Address, 8'h05);
        Branch_Target = 8'h20;
        cyc(1);
        Branch_Valid = 1'b0;
        check("coin_halted", Halted, 0);
        check("coin_addr2",  Address, 8'h20);
        check("coin_valid",  Out_Valid, 0);
        cyc(1);
        check("coin_pc", Out_PC, 8'h20);

        // PC wrap 8'hFF -> 8'h00.
        Branch_Valid  = 1'b1;
        Branch_Target = 8'hFE;
        cyc(1);
        Branch_Valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("wrap_valid", Out_Valid, 1);
            check("wrap_pc",    Out_PC, (8'hFE + k) & 8'hFF);
        end
        check("wrap_halted", Halted, 0);

        // Asynchronous reset between clock edges with the FIFO full.
        Out_Ready = 1'b0;
        cyc(3);
        check("ar_full_valid", Out_Valid, 1);
        #2;
        Reset = 1'b1;
        #1;
        check("ar_valid", Out_Valid, 0);
        check("ar_addr",  Address, 8'h00);
        check("ar_pc",    Out_PC, 0);
        Out_Ready = 1'b1;
        cyc(1);
        Reset = 1'b0;
        cyc(1);
        check("ar_first_valid", Out_Valid, 1);
        check("ar_first_pc",    Out_PC, 0);
        check("ar_first_instr", Out_Instruction, 8'h11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
